// File: rtl/stripe_lane_sched_pkg.sv
// Shared definitions for the transmit byte-striping lane scheduler.
// Holds the scheduler state encoding and the default geometry used by
// stripe_lane_sched and its lane finder.
package stripe_lane_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int LANES_DEF    = 4;
    localparam int DW_DEF       = 8;
    localparam int IDLE_GAP_DEF = 4;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/stripe_lane_sched_next.sv
// stripe_next_lane: combinational rotate-priority lane finder.
// Ports:
//   mask      in   LANES  set of usable lanes
//   lane_ptr  in   PTR_W  lane that is currently being served
//   next_lane out  PTR_W  next set bit of mask above lane_ptr, wrapping;
//                         lane_ptr itself when no other lane is set
//   low_lane  out  PTR_W  lowest set bit of mask (0 when mask is empty)
module stripe_next_lane
    import stripe_lane_sched_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int PTR_W = 2
) (
    input  logic [LANES-1:0] mask,
    input  logic [PTR_W-1:0] lane_ptr,
    output logic [PTR_W-1:0] next_lane,
    output logic [PTR_W-1:0] low_lane
);

    int         idx;
    logic       found_next;
    logic       found_low;

    // Scan upward from the lane after lane_ptr, wrapping once around; the
    // first enabled lane wins. Starting at offset 1 means a single-lane mask
    // finds nothing and the pointer simply stays put.
    always_comb begin
        next_lane  = lane_ptr;
        low_lane   = '0;
        found_next = 1'b0;
        found_low  = 1'b0;
        idx        = 0;
        for (int i = 0; i < LANES; i++) begin
            if (!found_low && mask[i]) begin
                low_lane  = PTR_W'(i);
                found_low = 1'b1;
            end
        end
        for (int i = 1; i < LANES; i++) begin
            idx = int'(lane_ptr) + i;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end
            if (!found_next && mask[PTR_W'(idx)]) begin
                next_lane  = PTR_W'(idx);
                found_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stripe_lane_sched.sv
// stripe_lane_sched: round-robin lane scheduler for the transmit striping
// path. Bytes from one valid/ready stream are written to the enabled lanes in
// ascending circular order; the enable mask is captured when a stream starts.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   valid_in, data_in   upstream byte stream
//   ready_out           byte accepted when valid_in & ready_out
//   lane_en             lane enable mask, sampled only while idle
//   lane_ready          per-lane sink ready
//   valid_out           one-hot write strobe per accepted byte
//   data_out            lane i data at [i*DW +: DW], held between strobes
//   lane_ptr            lane that receives the next accepted byte
//   byte_cnt            bytes accepted since reset (wrapping)
//   err_no_lane         sticky: stream offered with an empty lane mask
module stripe_lane_sched
    import stripe_lane_sched_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int DW       = DW_DEF,
    parameter int IDLE_GAP = IDLE_GAP_DEF,
    localparam int PTR_W   = $clog2(LANES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [DW-1:0]       data_in,
    output logic                ready_out,
    input  logic [LANES-1:0]    lane_en,
    input  logic [LANES-1:0]    lane_ready,
    output logic [LANES-1:0]    valid_out,
    output logic [LANES*DW-1:0] data_out,
    output logic [PTR_W-1:0]    lane_ptr,
    output logic [CNT_W-1:0]    byte_cnt,
    output logic                err_no_lane
);

    localparam int GAP_W = $clog2(IDLE_GAP + 1);

    state_t             state;
    state_t             state_nxt;
    logic [LANES-1:0]   mask;
    logic [LANES-1:0]   finder_mask;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PTR_W-1:0]   next_lane;
    logic [PTR_W-1:0]   low_lane;
    logic               start;
    logic               accept;
    logic               gap_done;

    // While idle the finder looks at the live enable mask so the first lane
    // can be chosen on the start edge; once running it uses the captured mask.
    assign finder_mask = (state == ST_IDLE) ? lane_en : mask;

    stripe_next_lane #(
        .LANES (LANES),
        .PTR_W (PTR_W)
    ) u_next_lane (
        .mask      (finder_mask),
        .lane_ptr  (lane_ptr),
        .next_lane (next_lane),
        .low_lane  (low_lane)
    );

    // Ready depends only on state and the target lane, never on valid_in.
    assign ready_out = (state == ST_RUN) && lane_ready[lane_ptr];
    assign accept    = ready_out && valid_in;
    assign start     = (state == ST_IDLE) && valid_in && (lane_en != '0);
    assign gap_done  = (state == ST_RUN) && !valid_in &&
                       (gap_cnt == GAP_W'(IDLE_GAP - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (gap_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and bookkeeping. The strobe is rebuilt every cycle so it is
    // high only for the cycle after an accept; lane data is held otherwise.
    // Any cycle with valid_in high, stalled or not, restarts the idle gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out   <= '0;
            data_out    <= '0;
            lane_ptr    <= '0;
            byte_cnt    <= '0;
            err_no_lane <= 1'b0;
            gap_cnt     <= '0;
            mask        <= '0;
        end else begin
            valid_out <= '0;
            if (state == ST_IDLE) begin
                gap_cnt <= '0;
                if (valid_in) begin
                    if (lane_en != '0) begin
                        mask     <= lane_en;
                        lane_ptr <= low_lane;
                    end else begin
                        err_no_lane <= 1'b1;
                    end
                end
            end else begin
                if (accept) begin
                    valid_out[lane_ptr]            <= 1'b1;
                    data_out[lane_ptr*DW +: DW]    <= data_in;
                    lane_ptr                       <= next_lane;
                    byte_cnt                       <= byte_cnt + CNT_W'(1);
                end
                if (valid_in) begin
                    gap_cnt <= '0;
                end else if (gap_done) begin
                    gap_cnt  <= '0;
                    lane_ptr <= '0;
                end else begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end
        end
    end

endmodule
